// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: sweeps the enabled channels in ascending order, 8-bit binary search each.
// Continuous re-sweeping is compiled in when SAR_CONT_MODE_EN is defined.
module sar_adc_ctrl #(
    parameter int MUX_CYC    = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic       mclk,
    input  logic       srst,
    input  logic       cfg_start,
    input  logic [3:0] cfg_chan_en,
`ifdef SAR_CONT_MODE_EN
    input  logic       cfg_cont,
`endif
    input  logic       comp_in,
    output logic [1:0] adc_sel,
    output logic [7:0] dac_code,
    output logic       busy,
    output logic       done,
    output logic [7:0] result0,
    output logic [7:0] result1,
    output logic [7:0] result2,
    output logic [7:0] result3
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_BIT  = 3'd2,
        ST_CMP  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t     state_r;
    logic [3:0] mask_r;
    logic [1:0] ch_r;
    logic [2:0] idx_r;
    logic [7:0] cnt_r;
    logic [1:0] comp_sync_r;
    logic [7:0] result_r [4];
    logic [7:0] kept_code_s;
    logic [7:0] next_trial_s;
    logic [2:0] next_ch_s;
    logic       cont_s;

    function automatic logic [1:0] lowest_chan(input logic [3:0] mask);
        logic [1:0] ch_v;
        ch_v = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                ch_v = 2'(i);
            end
        end
        return ch_v;
    endfunction

    // Returns {found, channel} for the first enabled channel above cur.
    function automatic logic [2:0] next_chan(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] nxt_v;
        nxt_v = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt_v = {1'b1, 2'(i)};
            end
        end
        return nxt_v;
    endfunction

`ifdef SAR_CONT_MODE_EN
    assign cont_s = cfg_cont;
`else
    assign cont_s = 1'b0;
`endif

    // Decision for the bit under test and the code for the following trial.
    always_comb begin
        if (comp_sync_r[1]) begin
            kept_code_s = dac_code;
        end else begin
            kept_code_s = dac_code & ~(8'd1 << idx_r);
        end
        next_trial_s = kept_code_s | (8'd1 << (idx_r - 3'd1));
        next_ch_s    = next_chan(mask_r, ch_r);
    end

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge mclk) begin
        if (srst) begin
            comp_sync_r <= 2'b00;
        end else begin
            comp_sync_r <= {comp_sync_r[0], comp_in};
        end
    end

    // Conversion sequencer with registered outputs.
    always_ff @(posedge mclk) begin
        if (srst) begin
            state_r  <= ST_IDLE;
            mask_r   <= 4'b0000;
            ch_r     <= 2'd0;
            idx_r    <= 3'd0;
            cnt_r    <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            adc_sel  <= 2'd0;
            dac_code <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                result_r[i] <= 8'h00;
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start && (cfg_chan_en != 4'b0000)) begin
                        mask_r   <= cfg_chan_en;
                        ch_r     <= lowest_chan(cfg_chan_en);
                        adc_sel  <= lowest_chan(cfg_chan_en);
                        dac_code <= 8'h00;
                        cnt_r    <= 8'd0;
                        busy     <= 1'b1;
                        state_r  <= ST_SEL;
                    end else if (cfg_start) begin
                        done <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEL: begin
                    adc_sel <= ch_r;
                    if (cnt_r == 8'(MUX_CYC - 1)) begin
                        cnt_r    <= 8'd0;
                        idx_r    <= 3'd7;
                        dac_code <= 8'h80;
                        state_r  <= ST_BIT;
                    end else begin
                        cnt_r    <= cnt_r + 8'd1;
                        dac_code <= 8'h00;
                    end
                end
                ST_BIT: begin
                    if (cnt_r == 8'(SETTLE_CYC - 1)) begin
                        cnt_r   <= 8'd0;
                        state_r <= ST_CMP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_CMP: begin
                    if (idx_r != 3'd0) begin
                        idx_r    <= idx_r - 3'd1;
                        dac_code <= next_trial_s;
                        state_r  <= ST_BIT;
                    end else begin
                        dac_code       <= kept_code_s;
                        result_r[ch_r] <= kept_code_s;
                        state_r        <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (next_ch_s[2]) begin
                        ch_r     <= next_ch_s[1:0];
                        adc_sel  <= next_ch_s[1:0];
                        dac_code <= 8'h00;
                        cnt_r    <= 8'd0;
                        state_r  <= ST_SEL;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    dac_code <= 8'h00;
                    cnt_r    <= 8'd0;
                    if (cont_s) begin
                        ch_r    <= lowest_chan(mask_r);
                        adc_sel <= lowest_chan(mask_r);
                        state_r <= ST_SEL;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign result0 = result_r[0];
    assign result1 = result_r[1];
    assign result2 = result_r[2];
    assign result3 = result_r[3];

endmodule
